// File: rtl/board_io_ctrl.sv
// Board memory port scheduler: host load stream, exclusive solver window, host readback stream.
// Owns the single port of the board memory and arbitrates it by controller state.
module board_io_ctrl #(
    parameter int unsigned CELLS = 81,
    parameter int unsigned AW    = 7,
    parameter int unsigned DW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_in_valid,
    input  logic [DW-1:0] i_in_data,
    output logic          o_in_ready,
    output logic          o_out_valid,
    output logic [DW-1:0] o_out_data,
    output logic          o_out_last,
    input  logic          i_out_ready,
    output logic          o_solver_rstn,
    output logic          o_solver_start,
    input  logic          i_solver_done,
    input  logic [AW-1:0] i_slv_addr,
    input  logic          i_slv_we,
    input  logic [DW-1:0] i_slv_wrdata,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic [DW-1:0] o_mem_wrdata,
    input  logic [DW-1:0] i_mem_rddata,
    output logic          o_busy,
    output logic          o_err,
    output logic          o_done
);

    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
    localparam logic [DW-1:0] MAX_DIGIT = DW'(9);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_SOLVE,
        S_RD,
        S_PRES
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_out_last;
    logic          r_pres_first;
    logic [DW-1:0] r_out_hold;
    logic          r_solver_rstn;
    logic          r_solver_start;
    logic          r_busy;
    logic          r_err;
    logic          r_done;

    logic          w_bad_digit;
    logic [DW-1:0] w_load_data;

    assign w_bad_digit = (i_in_data > MAX_DIGIT);
    assign w_load_data = w_bad_digit ? '0 : i_in_data;

    // Controller state, cell counter and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_in_ready     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_pres_first   <= 1'b0;
            r_out_hold     <= '0;
            r_solver_rstn  <= 1'b0;
            r_solver_start <= 1'b0;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_solver_start <= 1'b0;
            r_done         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_LOAD;
                        r_cnt      <= '0;
                        r_err      <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (i_in_valid) begin
                        if (w_bad_digit) begin
                            r_err <= 1'b1;
                        end
                        if (r_cnt == LAST_CELL) begin
                            r_state        <= S_KICK;
                            r_in_ready     <= 1'b0;
                            r_solver_rstn  <= 1'b1;
                            r_solver_start <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + AW'(1);
                        end
                    end
                end
                S_KICK: begin
                    r_state <= S_SOLVE;
                end
                S_SOLVE: begin
                    if (i_solver_done) begin
                        r_state <= S_RD;
                        r_cnt   <= '0;
                    end
                end
                S_RD: begin
                    r_state      <= S_PRES;
                    r_out_valid  <= 1'b1;
                    r_out_last   <= (r_cnt == LAST_CELL);
                    r_pres_first <= 1'b1;
                end
                S_PRES: begin
                    // First PRES cycle is when the synchronous read data arrives; freeze it
                    r_pres_first <= 1'b0;
                    if (r_pres_first) begin
                        r_out_hold <= i_mem_rddata;
                    end
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_state       <= S_IDLE;
                            r_done        <= 1'b1;
                            r_busy        <= 1'b0;
                            r_solver_rstn <= 1'b0;
                        end else begin
                            r_cnt   <= r_cnt + AW'(1);
                            r_state <= S_RD;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory port mux: host writes in LOAD, solver pass-through in SOLVE, counter address otherwise
    always_comb begin
        o_mem_addr   = r_cnt;
        o_mem_we     = 1'b0;
        o_mem_wrdata = '0;
        case (r_state)
            S_LOAD: begin
                o_mem_we     = i_in_valid;
                o_mem_wrdata = w_load_data;
            end
            S_SOLVE: begin
                o_mem_addr   = i_slv_addr;
                o_mem_we     = i_slv_we;
                o_mem_wrdata = i_slv_wrdata;
            end
            default: begin
                o_mem_addr = r_cnt;
            end
        endcase
    end

    assign o_in_ready     = r_in_ready;
    assign o_out_valid    = r_out_valid;
    assign o_out_data     = r_pres_first ? i_mem_rddata : r_out_hold;
    assign o_out_last     = r_out_last;
    assign o_solver_rstn  = r_solver_rstn;
    assign o_solver_start = r_solver_start;
    assign o_busy         = r_busy;
    assign o_err          = r_err;
    assign o_done         = r_done;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with a synchronous board memory model.
module tb_board_io_ctrl;

    localparam int unsigned CELLS = 81;
    localparam int unsigned AW    = 7;
    localparam int unsigned DW    = 4;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic          i_in_valid;
    logic [DW-1:0] i_in_data;
    logic          o_in_ready;
    logic          o_out_valid;
    logic [DW-1:0] o_out_data;
    logic          o_out_last;
    logic          i_out_ready;
    logic          o_solver_rstn;
    logic          o_solver_start;
    logic          i_solver_done;
    logic [AW-1:0] i_slv_addr;
    logic          i_slv_we;
    logic [DW-1:0] i_slv_wrdata;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_we;
    logic [DW-1:0] o_mem_wrdata;
    logic [DW-1:0] i_mem_rddata;
    logic          o_busy;
    logic          o_err;
    logic          o_done;

    board_io_ctrl #(.CELLS(CELLS), .AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_in_valid     (i_in_valid),
        .i_in_data      (i_in_data),
        .o_in_ready     (o_in_ready),
        .o_out_valid    (o_out_valid),
        .o_out_data     (o_out_data),
        .o_out_last     (o_out_last),
        .i_out_ready    (i_out_ready),
        .o_solver_rstn  (o_solver_rstn),
        .o_solver_start (o_solver_start),
        .i_solver_done  (i_solver_done),
        .i_slv_addr     (i_slv_addr),
        .i_slv_we       (i_slv_we),
        .i_slv_wrdata   (i_slv_wrdata),
        .o_mem_addr     (o_mem_addr),
        .o_mem_we       (o_mem_we),
        .o_mem_wrdata   (o_mem_wrdata),
        .i_mem_rddata   (i_mem_rddata),
        .o_busy         (o_busy),
        .o_err          (o_err),
        .o_done         (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:127];

    always @(posedge clk) begin
        if (o_mem_we) mem[o_mem_addr] <= o_mem_wrdata;
        i_mem_rddata <= mem[o_mem_addr];
    end

    int            n_cmp = 0;
    int            n_bad = 0;
    int            rb_cycles;
    logic [DW-1:0] board    [CELLS];
    logic [DW-1:0] exp_cell [CELLS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(o_in_ready), 32'(0));
        check({tag, "_out_valid"}, 32'(o_out_valid), 32'(0));
        check({tag, "_out_data"}, 32'(o_out_data), 32'(0));
        check({tag, "_out_last"}, 32'(o_out_last), 32'(0));
        check({tag, "_solver_rstn"}, 32'(o_solver_rstn), 32'(0));
        check({tag, "_solver_start"}, 32'(o_solver_start), 32'(0));
        check({tag, "_busy"}, 32'(o_busy), 32'(0));
        check({tag, "_err"}, 32'(o_err), 32'(0));
        check({tag, "_done"}, 32'(o_done), 32'(0));
        check({tag, "_mem_we"}, 32'(o_mem_we), 32'(0));
    endtask

    // Streams board[0..n-1] with continuous valid, checking each same-cycle write
    task automatic load_cells(input int n);
        for (int i = 0; i < n; i++) begin
            i_in_valid = 1'b1;
            i_in_data  = board[i];
            #1;
            check("ld_ready", 32'(o_in_ready), 32'(1));
            check("ld_we", 32'(o_mem_we), 32'(1));
            check("ld_addr", 32'(o_mem_addr), 32'(i));
            check("ld_wdata", 32'(o_mem_wrdata), 32'((board[i] > 4'd9) ? 4'd0 : board[i]));
            check("ld_rstn", 32'(o_solver_rstn), 32'(0));
            check("ld_excl", 32'(o_in_ready & o_out_valid), 32'(0));
            @(posedge clk);
            #1;
        end
        i_in_valid = 1'b0;
    endtask

    // Entered with the DUT in RD; mode 0 toggles ready every 3 cycles, mode 1 keeps it high
    task automatic readback(input int mode, output int cycles);
        int            beat    = 0;
        int            c       = 0;
        logic          stalled = 1'b0;
        logic [DW-1:0] prev    = '0;
        while (beat < int'(CELLS) && c < 2000) begin
            i_out_ready = (mode == 1) ? 1'b1 : (((c / 3) % 2) == 1);
            check("rb_excl", 32'(o_in_ready & o_out_valid), 32'(0));
            check("rb_rstn", 32'(o_solver_rstn), 32'(1));
            if (o_out_valid) begin
                check("rb_data", 32'(o_out_data), 32'(exp_cell[beat]));
                check("rb_last", 32'(o_out_last), 32'(beat == int'(CELLS) - 1));
                if (stalled) check("rb_hold", 32'(o_out_data), 32'(prev));
                prev    = o_out_data;
                stalled = !i_out_ready;
                if (i_out_ready) beat++;
            end else begin
                check("rb_last_idle", 32'(o_out_last), 32'(0));
                stalled = 1'b0;
            end
            c++;
            tick();
        end
        i_out_ready = 1'b0;
        check("rb_beats", 32'(beat), 32'(CELLS));
        check("rb_done_pulse", 32'(o_done), 32'(1));
        check("rb_busy_off", 32'(o_busy), 32'(0));
        check("rb_rstn_off", 32'(o_solver_rstn), 32'(0));
        check("rb_valid_off", 32'(o_out_valid), 32'(0));
        tick();
        check("rb_done_clear", 32'(o_done), 32'(0));
        cycles = c;
    endtask

    initial begin
        rst_n         = 1'b0;
        i_start       = 1'b0;
        i_in_valid    = 1'b0;
        i_in_data     = '0;
        i_out_ready   = 1'b0;
        i_solver_done = 1'b0;
        i_slv_addr    = '0;
        i_slv_we      = 1'b0;
        i_slv_wrdata  = '0;

        // Reset state, then abort a load at cell 40 with a bad digit already seen
        repeat (3) tick();
        check_all_zero("rst");
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < int'(CELLS); i++) board[i] = 4'((i * 5 + 2) % 10);
        board[3] = 4'hE;
        pulse_start();
        check("start_busy", 32'(o_busy), 32'(1));
        load_cells(40);
        check("abort_err_pre", 32'(o_err), 32'(1));
        check("abort_busy_pre", 32'(o_busy), 32'(1));
        i_in_valid = 1'b1;
        rst_n      = 1'b0;
        #1;
        check_all_zero("abort");
        i_in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_abort_idle_ready", 32'(o_in_ready), 32'(0));

        // Run 1: bad digit at cell 5, solver write during SOLVE, stalled readback
        for (int i = 0; i < int'(CELLS); i++) board[i] = 4'((i * 7 + 3) % 10);
        board[5] = 4'hC;
        pulse_start();
        check("r1_err_clear", 32'(o_err), 32'(0));
        load_cells(int'(CELLS));
        check("r1_kick_start", 32'(o_solver_start), 32'(1));
        check("r1_kick_rstn", 32'(o_solver_rstn), 32'(1));
        check("r1_kick_ready", 32'(o_in_ready), 32'(0));
        check("r1_err_set", 32'(o_err), 32'(1));
        check("r1_mem5", 32'(mem[5]), 32'(0));
        tick();
        check("r1_solve_start_low", 32'(o_solver_start), 32'(0));
        check("r1_solve_rstn", 32'(o_solver_rstn), 32'(1));
        i_slv_addr   = 7'd10;
        i_slv_we     = 1'b1;
        i_slv_wrdata = 4'd7;
        i_start      = 1'b1;
        #1;
        check("r1_slv_we", 32'(o_mem_we), 32'(1));
        check("r1_slv_addr", 32'(o_mem_addr), 32'(10));
        check("r1_slv_wdata", 32'(o_mem_wrdata), 32'(7));
        tick();
        i_slv_we = 1'b0;
        i_start  = 1'b0;
        check("r1_start_ignored", 32'(o_in_ready), 32'(0));
        check("r1_still_busy", 32'(o_busy), 32'(1));
        check("r1_start_no_pulse", 32'(o_solver_start), 32'(0));
        check("r1_mem10", 32'(mem[10]), 32'(7));
        i_solver_done = 1'b1;
        tick();
        check("r1_rd_addr", 32'(o_mem_addr), 32'(0));
        check("r1_rd_valid", 32'(o_out_valid), 32'(0));
        for (int i = 0; i < int'(CELLS); i++) exp_cell[i] = (board[i] > 4'd9) ? 4'd0 : board[i];
        exp_cell[10] = 4'd7;
        readback(0, rb_cycles);
        i_solver_done = 1'b0;
        check("r1_err_sticky", 32'(o_err), 32'(1));
        i_slv_addr = 7'd20;
        i_slv_we   = 1'b1;
        #1;
        check("idle_slv_we_blocked", 32'(o_mem_we), 32'(0));
        i_slv_we = 1'b0;
        tick();

        // Run 2: done already high at KICK, back-to-back puzzle, full-rate readback
        for (int i = 0; i < int'(CELLS); i++) board[i] = 4'((i * 3 + 1) % 10);
        pulse_start();
        check("r2_err_cleared", 32'(o_err), 32'(0));
        check("r2_ready", 32'(o_in_ready), 32'(1));
        load_cells(int'(CELLS));
        i_solver_done = 1'b1;
        check("r2_kick_start", 32'(o_solver_start), 32'(1));
        check("r2_err_none", 32'(o_err), 32'(0));
        tick();
        check("r2_solve_start_low", 32'(o_solver_start), 32'(0));
        check("r2_solve_valid", 32'(o_out_valid), 32'(0));
        tick();
        check("r2_rd_addr", 32'(o_mem_addr), 32'(0));
        check("r2_rd_valid", 32'(o_out_valid), 32'(0));
        for (int i = 0; i < int'(CELLS); i++) exp_cell[i] = board[i];
        readback(1, rb_cycles);
        check("r2_rb_cycles", 32'(rb_cycles), 32'(2 * CELLS));
        i_solver_done = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
